apb_cmd_master: RTL
===================

Name: apb_cmd_master

Overview:
APB master placed directly upstream of the apb_dp_mem slave. It accepts single read/write commands on a valid/ready port and issues them as APB4 transfers (IDLE→SETUP→ACCESS), with back-to-back transfers where possible. It collects PRDATA/PSLVERR into a response queue and terminates with an error any transfer that exceeds a PREADY timeout. Only one APB transfer is outstanding at a time.

Parameters:
TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout
RSP_DEPTH, 2, response FIFO entries; minimum 2

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_addr  in  ADDR_WIDTH  target address
cmd_write  in  1  1=write, 0=read
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  STRB_WIDTH  byte strobes (writes only)
rsp_valid  out  1  response at FIFO head
rsp_ready  in  1  consumer pops head
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_slverr  out  1  PSLVERR captured, or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  STRB_WIDTH  APB strobes
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset (PRESET high at a PCLK edge): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB = 0; response FIFO empty (rsp_valid=0, rsp_* = 0); timeout counter = 0. A reset during a transfer drops it at the next edge. No response is produced for it.
- States (apb_state_t): IDLE, SETUP, ACCESS.
- done = (state==ACCESS) && (PREADY || timeout_hit).
- free = RSP_DEPTH − count + pop − (done ? 1 : 0), where pop = rsp_valid && rsp_ready.
- cmd_ready = (state==IDLE || (done && !timeout_hit)) && free ≥ 1. This is a combinational function of state, PREADY, counter and FIFO state.
- On acceptance:
  - next state SETUP; PSEL=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA are registered from cmd_*.
  - PSTRB = cmd_write ? cmd_strb : 0.
- SETUP → ACCESS unconditionally; PENABLE=1.
- ACCESS with !done: hold all APB outputs; counter increments.
- ACCESS with done:
  - push {rdata = PWRITE ? 0 : PRDATA, slverr = PSLVERR || timeout_hit, timeout = timeout_hit}.
  - If a new command is accepted in the same cycle: go to SETUP with PSEL held at 1, PENABLE=0.
  - Otherwise go to IDLE with PSEL=0, PENABLE=0.
- In IDLE, PADDR/PWRITE/PWDATA/PSTRB hold their last values. PSEL=0, PENABLE=0.
- Timeout:
  - The counter resets to 0 on entry to ACCESS.
  - timeout_hit = TIMEOUT_CYCLES≠0 && counter == TIMEOUT_CYCLES−1 && !PREADY.
  - If PREADY and timeout_hit would coincide, PREADY wins (normal completion).
  - After a timeout the next state is always IDLE.
- Latency: command accepted at edge N → SETUP in cycle N+1 → ACCESS in N+2. If PREADY is high in N+2, rsp_valid goes high in N+3.
- The FIFO is first-word-fall-through. Simultaneous push and pop is legal at any count. By the cmd_ready rule, a push can never hit a full FIFO. An assertion checks this.
- PSLVERR and PRDATA are sampled only in the done cycle.

Decomposition:
- apb_pkg (existing): ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH, addr_t, data_t, strb_t, apb_state_t.
- Add to apb_pkg: typedef struct packed apb_rsp_t {data_t rdata; logic slverr; logic timeout;}.
- One sub-module, apb_rsp_fifo: parameter DEPTH, payload apb_rsp_t, push/pop/count, synchronous active-high reset.

Test Plan:
- Write addr 0x020, wdata 0xDEADBEEF, strb 0xF to apb_dp_mem (4 ACCESS cycles) → PSEL high for 5 cycles, PENABLE for 4; one response with slverr=0, timeout=0, rdata=0.
- Read back 0x020 (2 ACCESS cycles) → rsp_rdata=0xDEADBEEF; PSTRB=0 throughout the transfer.
- Write to read-only address 0x005 → PREADY in the first ACCESS cycle; rsp_slverr=1, rsp_timeout=0.
- Three back-to-back reads with rsp_ready=1 → PSEL stays high between transfers (ACCESS→SETUP); three responses delivered in order.
- Hold rsp_ready=0 and issue 3 commands → only 2 transfers run; cmd_ready=0 until rsp_ready pops an entry; the third completes afterwards.
- Stub slave with PREADY tied 0, TIMEOUT_CYCLES=16 → exactly 16 ACCESS cycles, then PSEL=0; response slverr=1, timeout=1, rdata=0.
- Assert PRESET in the second ACCESS cycle → PSEL=0 at the next edge; no response pushed.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types: bus widths, master state encoding and response payload.
// Used by the command master and its response FIFO.
package apb_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        data_t rdata;
        logic  slverr;
        logic  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_rsp_fifo.sv
// First-word-fall-through response queue. Head reads as zero when empty;
// push and pop may coincide at any occupancy.
module apb_rsp_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  apb_rsp_t                   push_data,
    input  logic                       pop,
    output apb_rsp_t                   head,
    output logic                       not_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    apb_rsp_t      mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; the head is gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign not_empty = (count != '0);
    assign head      = not_empty ? mem[rd_ptr] : '0;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == CW'(DEPTH)));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && count == '0));

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 master: turns valid/ready commands into SETUP/ACCESS
// transfers, aborts stalled transfers after a PREADY timeout, queues responses.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RSP_DEPTH      = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  addr_t      cmd_addr,
    input  logic       cmd_write,
    input  data_t      cmd_wdata,
    input  strb_t      cmd_strb,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output data_t      rsp_rdata,
    output logic       rsp_slverr,
    output logic       rsp_timeout,
    output addr_t      PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output data_t      PWDATA,
    output strb_t      PSTRB,
    input  data_t      PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    output apb_state_t dbg_state
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    apb_state_t    state;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;
    logic          done;
    logic          pop;
    logic          accept;
    int            free_slots;
    apb_rsp_t      push_data;
    apb_rsp_t      rsp_head;
    logic          rsp_not_empty;
    logic [CW-1:0] rsp_count;

    // Handshakes (cmd and rsp): a beat transfers on a rising edge where valid
    // and ready are both high; valid never waits on ready, ready may depend on
    // the consumer side (rsp_ready frees a slot in the same cycle).
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && (to_cnt == TO_LAST) && !PREADY;
        done        = (state == ACCESS) && (PREADY || timeout_hit);
        pop         = rsp_not_empty && rsp_ready;
        free_slots  = RSP_DEPTH - int'(rsp_count) + int'(pop) - int'(done);
        cmd_ready   = ((state == IDLE) || (done && !timeout_hit)) && (free_slots >= 1);
        accept      = cmd_valid && cmd_ready;

        push_data.rdata   = (PWRITE || timeout_hit) ? '0 : PRDATA;
        push_data.slverr  = PSLVERR || timeout_hit;
        push_data.timeout = timeout_hit;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            to_cnt  <= '0;
        end else begin
            case (state)
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                    to_cnt  <= '0;
                end
                ACCESS: begin
                    if (done) begin
                        state   <= IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // Acceptance (from IDLE or a clean completion) overrides the
            // return to IDLE so PSEL stays high for back-to-back transfers.
            if (accept) begin
                state   <= SETUP;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PADDR   <= cmd_addr;
                PWRITE  <= cmd_write;
                PWDATA  <= cmd_wdata;
                PSTRB   <= cmd_write ? cmd_strb : '0;
            end
        end
    end

    apb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (PCLK),
        .rst       (PRESET),
        .push      (done),
        .push_data (push_data),
        .pop       (pop),
        .head      (rsp_head),
        .not_empty (rsp_not_empty),
        .count     (rsp_count)
    );

    assign rsp_valid   = rsp_not_empty;
    assign rsp_rdata   = rsp_head.rdata;
    assign rsp_slverr  = rsp_head.slverr;
    assign rsp_timeout = rsp_head.timeout;
    assign dbg_state   = state;

endmodule
